apb_alu_slave: RTL and testbench
================================

Name: apb_alu_slave

Overview:
- APB3 completer wrapping a small multi-cycle ALU.
- Sits directly downstream of the command controller's APB master; one instance is placed per PSEL line.
- Operands and opcode are written over APB; the result is read back over APB, and the controller stores it to memory.
- Wait states (PREADY low) hide the latency of the iterative multiplier.

Parameters:
ADDR_WIDTH, 2, APB address width; only the low 2 bits are decoded.
DATA_WIDTH, 16, APB data width and ALU operand/result width; must be at least 8.

Ports:
i_PCLK  in  1  APB clock; the only clock in the block.
i_PRESETn  in  1  asynchronous, active-low reset.
i_PADDR  in  ADDR_WIDTH  register address.
i_PSEL  in  1  select for this completer.
i_PENABLE  in  1  APB access phase.
i_PWRITE  in  1  1 = write, 0 = read.
i_PWDATA  in  DATA_WIDTH  write data.
o_PREADY  out  1  transfer complete.
o_PRDATA  out  DATA_WIDTH  read data; valid only when PSEL & PENABLE & PREADY & !PWRITE.
o_PSLVERR  out  1  error response; valid only in the PREADY cycle.

Behaviour:
- Reset (asynchronous assert, synchronous release): o_PREADY=0, o_PRDATA=0, o_PSLVERR=0, all registers 0, core idle, done=0.
- Register map:
  - 0 = OPA (RW).
  - 1 = OPB (RW).
  - 2 = CTRL. Write bits[3:0] = opcode, which starts the operation. Read = {busy, done, zero, carry, zeros..., opcode[3:0]}; busy is the MSB.
  - 3 = RESULT (RO).
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 6 SHL, 7 SHR: shift amount is OPB[3:0]; single-cycle core latency.
  - 5 MUL: shift-add, low DATA_WIDTH bits of the product; DATA_WIDTH core cycles.
- carry:
  - ADD: carry out.
  - SUB: borrow (OPA < OPB unsigned).
  - MUL: 1 if the upper product half is nonzero.
  - All other opcodes: 0.
- zero = (RESULT == 0).
- Bus FSM states IDLE, ACCESS, WAIT:
  - IDLE -> ACCESS on PSEL & !PENABLE (setup phase).
  - In ACCESS, PREADY=1 in the same cycle as PENABLE, unless a stall condition applies, in which case go to WAIT with PREADY=0.
  - WAIT -> PREADY=1 in the cycle after busy falls.
  - After a completed transfer, return to IDLE, or to ACCESS on back-to-back SETUP.
- Stall conditions while busy=1: any write, or a read of RESULT. Reads of OPA, OPB and CTRL never stall.
- Write commit:
  - Register update and core start happen at the PREADY=1 edge.
  - busy rises the cycle after the CTRL write completes.
  - done clears at start and sets when the result is latched.
- PSLVERR=1 with PREADY, and no state change, for:
  - a write to RESULT;
  - a CTRL write with an unsupported opcode;
  - a read of RESULT when done=0 and busy=0 (no result available).
- Aborted transfer: PSEL dropped during WAIT returns the FSM to IDLE. The core keeps running and no write is committed.
- Reset mid-operation aborts the core; all state returns to reset values.
- Width rules: ADD/SUB are DATA_WIDTH+1 bits internally; SHL/SHR are logical, and a shift of DATA_WIDTH or more gives 0.

Optional Feature:
ALU_DIV_EN
- Defined:
  - Opcode 8 DIV: restoring unsigned division, DATA_WIDTH core cycles, RESULT = quotient.
  - Opcode 9 REM: same algorithm, RESULT = remainder.
  - Divide by zero: no iteration; RESULT = all-ones, done=1 next cycle, carry=1, and the subsequent RESULT read returns PSLVERR=1 (data still all-ones).
- Undefined: opcodes 8-15 are unsupported and return PSLVERR on the CTRL write.

Decomposition:
- Package apb_alu_pkg:
  - opcode enum (4-bit);
  - register address localparams ADDR_OPA/OPB/CTRL/RESULT;
  - CTRL bit-index constants;
  - bus FSM state enum.
- Sub-module apb_alu_core:
  - handshake i_start/i_opcode/i_a/i_b -> o_busy/o_done/o_result/o_carry/o_divz;
  - contains the iterative MUL (and DIV/REM) datapath with a log2(DATA_WIDTH)+1 bit iteration counter.
- The top level holds the APB FSM and the register file only.

Test Plan:
- ADD: write OPA=0x7FFF, OPB=0x0001, CTRL=0 -> RESULT read PREADY without wait state = 0x8000; CTRL read carry=0, zero=0, done=1.
- SUB with borrow: write OPA=3, OPB=5, CTRL=1 -> RESULT=0xFFFE, carry=1.
- MUL stall: write OPA=0x0102, OPB=0x0003, CTRL=5, then immediately read RESULT -> PREADY held low about 16 cycles, then data 0x0306, carry=0. OPA=0x1000 × OPB=0x0010 -> RESULT=0x0000, zero=1, carry=1.
- Errors:
  - write RESULT -> PSLVERR=1 and RESULT unchanged;
  - RESULT read after reset -> PSLVERR=1;
  - CTRL write opcode 8 with ALU_DIV_EN undefined -> PSLVERR=1, busy stays 0.
- Reset mid-MUL: assert i_PRESETn low 5 cycles after the CTRL write -> all outputs 0 immediately; CTRL reads 0 after release.
- ALU_DIV_EN:
  - OPA=100, OPB=7, CTRL=8 -> RESULT=14; CTRL=9 -> RESULT=2.
  - OPB=0, CTRL=8 -> RESULT=0xFFFF with PSLVERR=1.

Source files
------------

// File: rtl/apb_alu_pkg.sv
// Shared definitions for the APB ALU completer: opcodes, register map,
// CTRL bit positions and the bus FSM states.
// Optional feature macro: ALU_DIV_EN (adds DIV/REM opcodes 8 and 9).
package apb_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_MUL = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_DIV = 4'd8,
        OP_REM = 4'd9
    } opcode_e;

    localparam logic [1:0] ADDR_OPA    = 2'd0;
    localparam logic [1:0] ADDR_OPB    = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_RESULT = 2'd3;

    // Status flags are counted down from the MSB of the data word,
    // the opcode sits in the low nibble.
    localparam int CTRL_BUSY_FROM_MSB  = 0;
    localparam int CTRL_DONE_FROM_MSB  = 1;
    localparam int CTRL_ZERO_FROM_MSB  = 2;
    localparam int CTRL_CARRY_FROM_MSB = 3;
    localparam int CTRL_OPC_LSB        = 0;
    localparam int CTRL_OPC_W          = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2
    } bus_state_e;

    // Opcodes the core can execute in this build.
    function automatic logic op_supported(input logic [3:0] op);
`ifdef ALU_DIV_EN
        return (op <= 4'd9);
`else
        return (op <= 4'd7);
`endif
    endfunction

endpackage

// File: rtl/apb_alu_core.sv
// Multi-cycle ALU core. Single-cycle ops finish one cycle after start;
// MUL (shift-add) and, with ALU_DIV_EN, DIV/REM (restoring) iterate
// DATA_WIDTH cycles. Result and flags are held until the next start.
// Optional feature macro: ALU_DIV_EN.
module apb_alu_core
#(
    parameter int DATA_WIDTH = 16
)
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [3:0]            i_opcode,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic                  o_carry,
    output logic                  o_divz
);
    import apb_alu_pkg::*;

    localparam int CW = $clog2(DATA_WIDTH) + 1;

    logic                    r_busy;
    logic                    r_done;
    opcode_e                 r_op;
    logic [DATA_WIDTH-1:0]   r_a;
    logic [DATA_WIDTH-1:0]   r_b;
    logic [2*DATA_WIDTH-1:0] r_acc;
    logic [CW-1:0]           r_cnt;
    logic [DATA_WIDTH-1:0]   r_result;
    logic                    r_carry;
    logic                    r_divz;

    logic                    w_fin;
    logic [DATA_WIDTH-1:0]   w_res;
    logic                    w_cry;
    logic                    w_divz;
    logic [DATA_WIDTH-1:0]   w_a_nxt;
    logic [DATA_WIDTH-1:0]   w_b_nxt;
    logic [2*DATA_WIDTH-1:0] w_acc_nxt;
    logic                    w_last;
    logic [3:0]              w_amt;
    logic [DATA_WIDTH:0]     w_sum;
    logic [DATA_WIDTH:0]     w_diff;
    logic [DATA_WIDTH:0]     w_msum;
    logic [2*DATA_WIDTH-1:0] w_mul_acc;

    assign w_amt  = r_b[3:0];
    assign w_last = (r_cnt == CW'(DATA_WIDTH - 1));
    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};

    // Shift-add step: add the multiplicand into the upper half, then shift
    // the whole accumulator right; after DATA_WIDTH steps it holds a*b.
    assign w_msum    = {1'b0, r_acc[2*DATA_WIDTH-1:DATA_WIDTH]}
                     + (r_b[0] ? {1'b0, r_a} : {(DATA_WIDTH+1){1'b0}});
    assign w_mul_acc = {w_msum, r_acc[DATA_WIDTH-1:1]};

`ifdef ALU_DIV_EN
    // Restoring division step: r_a shifts the dividend out and the
    // quotient bits in, r_acc low half carries the partial remainder.
    logic [DATA_WIDTH:0]   w_rsh;
    logic [DATA_WIDTH:0]   w_rsub;
    logic                  w_rge;
    logic [DATA_WIDTH-1:0] w_rnew;
    logic [DATA_WIDTH-1:0] w_qnew;

    assign w_rsh  = {r_acc[DATA_WIDTH-1:0], r_a[DATA_WIDTH-1]};
    assign w_rsub = w_rsh - {1'b0, r_b};
    assign w_rge  = (w_rsh >= {1'b0, r_b});
    assign w_rnew = w_rge ? w_rsub[DATA_WIDTH-1:0] : w_rsh[DATA_WIDTH-1:0];
    assign w_qnew = {r_a[DATA_WIDTH-2:0], w_rge};
`endif

    // One execution cycle of the current operation.
    always_comb begin
        w_fin     = 1'b0;
        w_res     = r_result;
        w_cry     = 1'b0;
        w_divz    = 1'b0;
        w_a_nxt   = r_a;
        w_b_nxt   = r_b;
        w_acc_nxt = r_acc;
        case (r_op)
            OP_ADD: begin
                w_fin = 1'b1;
                w_res = w_sum[DATA_WIDTH-1:0];
                w_cry = w_sum[DATA_WIDTH];
            end
            OP_SUB: begin
                w_fin = 1'b1;
                w_res = w_diff[DATA_WIDTH-1:0];
                w_cry = w_diff[DATA_WIDTH];
            end
            OP_AND: begin
                w_fin = 1'b1;
                w_res = r_a & r_b;
            end
            OP_OR: begin
                w_fin = 1'b1;
                w_res = r_a | r_b;
            end
            OP_XOR: begin
                w_fin = 1'b1;
                w_res = r_a ^ r_b;
            end
            OP_SHL: begin
                w_fin = 1'b1;
                w_res = (int'(w_amt) >= DATA_WIDTH) ? '0 : (r_a << w_amt);
            end
            OP_SHR: begin
                w_fin = 1'b1;
                w_res = (int'(w_amt) >= DATA_WIDTH) ? '0 : (r_a >> w_amt);
            end
            OP_MUL: begin
                w_acc_nxt = w_mul_acc;
                w_b_nxt   = r_b >> 1;
                if (w_last) begin
                    w_fin = 1'b1;
                    w_res = w_mul_acc[DATA_WIDTH-1:0];
                    w_cry = |w_mul_acc[2*DATA_WIDTH-1:DATA_WIDTH];
                end
            end
`ifdef ALU_DIV_EN
            OP_DIV, OP_REM: begin
                if (r_b == '0) begin
                    // Divide by zero skips the iteration entirely.
                    w_fin  = 1'b1;
                    w_res  = '1;
                    w_cry  = 1'b1;
                    w_divz = 1'b1;
                end else begin
                    w_acc_nxt = {{DATA_WIDTH{1'b0}}, w_rnew};
                    w_a_nxt   = w_qnew;
                    if (w_last) begin
                        w_fin = 1'b1;
                        w_res = (r_op == OP_DIV) ? w_qnew : w_rnew;
                    end
                end
            end
`endif
            default: begin
                w_fin = 1'b1;
                w_res = '0;
            end
        endcase
    end

    // Operation sequencing: load on start, iterate while busy, latch on finish.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_op     <= OP_ADD;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_divz   <= 1'b0;
        end else if (i_start && !r_busy) begin
            r_busy <= 1'b1;
            r_done <= 1'b0;
            r_divz <= 1'b0;
            r_op   <= opcode_e'(i_opcode);
            r_a    <= i_a;
            r_b    <= i_b;
            r_acc  <= '0;
            r_cnt  <= '0;
        end else if (r_busy) begin
            r_a   <= w_a_nxt;
            r_b   <= w_b_nxt;
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + CW'(1);
            if (w_fin) begin
                r_busy   <= 1'b0;
                r_done   <= 1'b1;
                r_result <= w_res;
                r_carry  <= w_cry;
                r_divz   <= w_divz;
            end
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_result = r_result;
    assign o_carry  = r_carry;
    assign o_divz   = r_divz;

endmodule

// File: rtl/apb_alu_slave.sv
// APB3 completer in front of apb_alu_core. Holds the bus FSM and the
// OPA/OPB/opcode registers; inserts wait states while the core is busy
// for writes and RESULT reads.
// Optional feature macro: ALU_DIV_EN (enables DIV/REM in the core).
module apb_alu_slave
#(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 16
)
(
    input  logic                  i_PCLK,
    input  logic                  i_PRESETn,
    input  logic [ADDR_WIDTH-1:0] i_PADDR,
    input  logic                  i_PSEL,
    input  logic                  i_PENABLE,
    input  logic                  i_PWRITE,
    input  logic [DATA_WIDTH-1:0] i_PWDATA,
    output logic                  o_PREADY,
    output logic [DATA_WIDTH-1:0] o_PRDATA,
    output logic                  o_PSLVERR
);
    import apb_alu_pkg::*;

    bus_state_e            r_state;
    bus_state_e            w_state_nxt;
    logic [DATA_WIDTH-1:0] r_opa;
    logic [DATA_WIDTH-1:0] r_opb;
    logic [3:0]            r_opcode;

    logic [1:0]            w_addr;
    logic                  w_busy;
    logic                  w_done;
    logic                  w_carry;
    logic                  w_divz;
    logic [DATA_WIDTH-1:0] w_result;
    logic                  w_zero;
    logic                  w_stall;
    logic                  w_ready;
    logic                  w_err;
    logic                  w_commit;
    logic                  w_start;
    logic [DATA_WIDTH-1:0] w_ctrl;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_addr = i_PADDR[1:0];
    // zero reflects a latched result, so it reads 0 until the first op completes.
    assign w_zero = w_done && (w_result == '0);
    // Writes and RESULT reads must wait for the core; OPA/OPB/CTRL reads never do.
    assign w_stall  = w_busy && (i_PWRITE || (w_addr == ADDR_RESULT));
    assign w_commit = w_ready && i_PWRITE && !w_err;
    assign w_start  = w_commit && (w_addr == ADDR_CTRL);

    // Error response for the transfer currently on the bus.
    always_comb begin
        w_err = 1'b0;
        if (i_PWRITE) begin
            if (w_addr == ADDR_RESULT) begin
                w_err = 1'b1;
            end else if ((w_addr == ADDR_CTRL) && !op_supported(i_PWDATA[3:0])) begin
                w_err = 1'b1;
            end
        end else if (w_addr == ADDR_RESULT) begin
            w_err = (!w_done && !w_busy) || w_divz;
        end
    end

    // CTRL read image: busy, done, zero, carry from the MSB down, opcode in the low nibble.
    always_comb begin
        w_ctrl = '0;
        w_ctrl[DATA_WIDTH-1-CTRL_BUSY_FROM_MSB]  = w_busy;
        w_ctrl[DATA_WIDTH-1-CTRL_DONE_FROM_MSB]  = w_done;
        w_ctrl[DATA_WIDTH-1-CTRL_ZERO_FROM_MSB]  = w_zero;
        w_ctrl[DATA_WIDTH-1-CTRL_CARRY_FROM_MSB] = w_carry;
        w_ctrl[CTRL_OPC_LSB +: CTRL_OPC_W]       = r_opcode;
    end

    // Read data selection by register address.
    always_comb begin
        w_rdata = '0;
        case (w_addr)
            ADDR_OPA:    w_rdata = r_opa;
            ADDR_OPB:    w_rdata = r_opb;
            ADDR_CTRL:   w_rdata = w_ctrl;
            ADDR_RESULT: w_rdata = w_result;
            default:     w_rdata = '0;
        endcase
    end

    // Bus FSM state register.
    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bus FSM next state and PREADY; dropping PSEL outside IDLE abandons the transfer.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_PSEL && !i_PENABLE) begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_ready = i_PSEL && i_PENABLE && !w_stall;
                if (!i_PSEL || w_ready) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_stall) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_ready = i_PSEL && i_PENABLE && !w_stall;
                if (!i_PSEL || w_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Register file; only error-free completed writes change state.
    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn) begin
            r_opa    <= '0;
            r_opb    <= '0;
            r_opcode <= '0;
        end else if (w_commit) begin
            case (w_addr)
                ADDR_OPA:  r_opa    <= i_PWDATA;
                ADDR_OPB:  r_opb    <= i_PWDATA;
                ADDR_CTRL: r_opcode <= i_PWDATA[3:0];
                default:   ;
            endcase
        end
    end

    apb_alu_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .i_clk    (i_PCLK),
        .i_rst_n  (i_PRESETn),
        .i_start  (w_start),
        .i_opcode (i_PWDATA[3:0]),
        .i_a      (r_opa),
        .i_b      (r_opb),
        .o_busy   (w_busy),
        .o_done   (w_done),
        .o_result (w_result),
        .o_carry  (w_carry),
        .o_divz   (w_divz)
    );

    assign o_PREADY  = w_ready;
    assign o_PSLVERR = w_ready && w_err;
    assign o_PRDATA  = (w_ready && !i_PWRITE) ? w_rdata : '0;

endmodule

// File: tb/tb_apb_alu_slave.sv
// Self-checking bench for apb_alu_slave (DATA_WIDTH=16).
module tb_apb_alu_slave;

    logic        clk;
    logic        rst_n;
    logic [1:0]  paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [15:0] pwdata;
    logic        pready;
    logic [15:0] prdata;
    logic        pslverr;

    int checks   = 0;
    int failures = 0;

`ifdef ALU_DIV_EN
    localparam int MAX_OP = 9;
`else
    localparam int MAX_OP = 7;
`endif

    // Reference state of the completer as seen from the bus.
    logic [15:0] exp_res;
    logic [15:0] exp_ctrl;
    logic        exp_rerr;
    logic [15:0] exp_opa;

    apb_alu_slave #(.ADDR_WIDTH(2), .DATA_WIDTH(16)) dut (
        .i_PCLK    (clk),
        .i_PRESETn (rst_n),
        .i_PADDR   (paddr),
        .i_PSEL    (psel),
        .i_PENABLE (penable),
        .i_PWRITE  (pwrite),
        .i_PWDATA  (pwdata),
        .o_PREADY  (pready),
        .o_PRDATA  (prdata),
        .o_PSLVERR (pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Arithmetic meaning of each opcode, straight from the opcode definitions.
    task automatic model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] r, output logic cy, output logic dz);
        longint unsigned ua, ub, amt, p;
        ua = a; ub = b; amt = b & 16'h000F;
        r = 16'h0; cy = 1'b0; dz = 1'b0;
        case (op)
            4'd0: begin p = ua + ub; r = 16'(p); cy = (p > 65535); end
            4'd1: begin r = 16'(ua - ub); cy = (ua < ub); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: begin p = ua * ub; r = 16'(p); cy = ((p >> 16) != 0); end
            4'd6: r = (amt >= 16) ? 16'h0 : 16'(ua << amt);
            4'd7: r = (amt >= 16) ? 16'h0 : 16'(ua >> amt);
            4'd8: if (ub == 0) begin r = 16'hFFFF; cy = 1'b1; dz = 1'b1; end
                  else r = 16'(ua / ub);
            4'd9: if (ub == 0) begin r = 16'hFFFF; cy = 1'b1; dz = 1'b1; end
                  else r = 16'(ua % ub);
            default: ;
        endcase
    endtask

    // One APB transfer: setup, access, then wait (bounded) for PREADY.
    task automatic apb(input logic wr, input logic [1:0] a, input logic [15:0] d,
                       output logic [15:0] rd, output logic err, output int waits);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0;
        @(negedge clk);
        while (pready !== 1'b1 && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (pready !== 1'b1) begin
            checks++;
            failures++;
            $error("FAIL apb_timeout addr=%0d observed_pready=%b required=1", a, pready);
        end
        rd  = prdata;
        err = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic apply_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic cy, dz;
        model(op, a, b, r, cy, dz);
        exp_res  = r;
        exp_rerr = dz;
        exp_ctrl = {1'b0, 1'b1, (r == 16'h0), cy, 8'h00, op};
    endtask

    // Load operands, start op, read RESULT immediately, then read CTRL.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, output int res_waits);
        logic [15:0] rdat;
        logic e;
        int w;
        logic sup;
        apb(1'b1, 2'd0, a, rdat, e, w);
        exp_opa = a;
        apb(1'b1, 2'd1, b, rdat, e, w);
        apb(1'b1, 2'd2, {12'h000, op}, rdat, e, w);
        sup = (int'(op) <= MAX_OP);
        chk({tag, "_ctrl_wr_err"}, e, !sup);
        if (sup) apply_model(op, a, b);
        apb(1'b0, 2'd3, 16'h0, rdat, e, res_waits);
        chk({tag, "_result"}, rdat, exp_res);
        chk({tag, "_result_err"}, e, exp_rerr);
        apb(1'b0, 2'd2, 16'h0, rdat, e, w);
        chk({tag, "_ctrl_rd"}, rdat, exp_ctrl);
    endtask

    initial begin
        logic [15:0] rdat;
        logic e;
        int w;
        int rw;
        logic [3:0] op;
        logic [15:0] a, b;

        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 2'd0; pwdata = 16'h0;
        exp_res = 16'h0; exp_ctrl = 16'h0; exp_rerr = 1'b1; exp_opa = 16'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pready", pready, 1'b0);
        chk("rst_prdata", prdata, 16'h0);
        chk("rst_pslverr", pslverr, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // State straight after reset.
        apb(1'b0, 2'd2, 16'h0, rdat, e, w);
        chk("rst_ctrl", rdat, 16'h0);
        apb(1'b0, 2'd3, 16'h0, rdat, e, w);
        chk("rst_result_err", e, 1'b1);
        apb(1'b0, 2'd0, 16'h0, rdat, e, w);
        chk("rst_opa", rdat, 16'h0);

        // Directed arithmetic.
        run_op("add", 4'd0, 16'h7FFF, 16'h0001, rw);
        chk("add_no_wait", rw, 0);
        chk("add_value", exp_res, 16'h8000);
        run_op("sub", 4'd1, 16'h0003, 16'h0005, rw);
        chk("sub_ctrl_fixed", exp_ctrl, 16'h5001);
        run_op("mul", 4'd5, 16'h0102, 16'h0003, rw);
        chk("mul_stalled", (rw >= 8 && rw <= 16), 1'b1);
        chk("mul_value", exp_res, 16'h0306);
        run_op("mul_ovf", 4'd5, 16'h1000, 16'h0010, rw);
        chk("mul_ovf_ctrl_fixed", exp_ctrl, 16'h7005);
        run_op("shl", 4'd6, 16'h00F1, 16'h0004, rw);
        run_op("shr", 4'd7, 16'h8000, 16'h000F, rw);

        // Error responses leave state untouched.
        apb(1'b1, 2'd3, 16'h1234, rdat, e, w);
        chk("wr_result_err", e, 1'b1);
        apb(1'b0, 2'd3, 16'h0, rdat, e, w);
        chk("wr_result_unchanged", rdat, exp_res);
        chk("wr_result_rd_err", e, 1'b0);
`ifdef ALU_DIV_EN
        run_op("div", 4'd8, 16'd100, 16'd7, rw);
        chk("div_value", exp_res, 16'd14);
        run_op("rem", 4'd9, 16'd100, 16'd7, rw);
        chk("rem_value", exp_res, 16'd2);
        run_op("divz", 4'd8, 16'd100, 16'd0, rw);
        chk("divz_err_expected", exp_rerr, 1'b1);
        apb(1'b1, 2'd2, 16'h000A, rdat, e, w);
        chk("op10_err", e, 1'b1);
`else
        apb(1'b1, 2'd2, 16'h0008, rdat, e, w);
        chk("op8_err", e, 1'b1);
`endif
        apb(1'b0, 2'd2, 16'h0, rdat, e, w);
        chk("bad_op_ctrl_unchanged", rdat, exp_ctrl);

        // CTRL read during MUL never stalls; a write during MUL does.
        apb(1'b1, 2'd0, 16'h0102, rdat, e, w);
        apb(1'b1, 2'd1, 16'h0003, rdat, e, w);
        apb(1'b1, 2'd2, 16'h0005, rdat, e, w);
        apply_model(4'd5, 16'h0102, 16'h0003);
        apb(1'b0, 2'd2, 16'h0, rdat, e, w);
        chk("busy_ctrl_no_wait", w, 0);
        chk("busy_ctrl_bit", rdat[15], 1'b1);
        apb(1'b1, 2'd0, 16'h0005, rdat, e, w);
        chk("busy_write_stalls", (w > 0), 1'b1);
        exp_opa = 16'h0005;
        apb(1'b0, 2'd3, 16'h0, rdat, e, w);
        chk("busy_mul_old_operands", rdat, 16'h0306);
        apb(1'b0, 2'd0, 16'h0, rdat, e, w);
        chk("busy_write_committed", rdat, exp_opa);

        // Abort a stalled write by dropping PSEL; nothing is committed.
        apb(1'b1, 2'd2, 16'h0005, rdat, e, w);
        apply_model(4'd5, 16'h0005, 16'h0003);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 2'd0; pwdata = 16'hABCD;
        @(posedge clk); #1;
        penable = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_stalled", pready, 1'b0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        apb(1'b0, 2'd3, 16'h0, rdat, e, w);
        chk("abort_result", rdat, exp_res);
        apb(1'b0, 2'd0, 16'h0, rdat, e, w);
        chk("abort_opa_kept", rdat, exp_opa);

        // Reset in the middle of a multiply.
        apb(1'b1, 2'd2, 16'h0005, rdat, e, w);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_pready", pready, 1'b0);
        chk("midrst_prdata", prdata, 16'h0);
        chk("midrst_pslverr", pslverr, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_res = 16'h0; exp_ctrl = 16'h0; exp_rerr = 1'b1; exp_opa = 16'h0;
        apb(1'b0, 2'd2, 16'h0, rdat, e, w);
        chk("midrst_ctrl", rdat, 16'h0);
        apb(1'b0, 2'd0, 16'h0, rdat, e, w);
        chk("midrst_opa", rdat, 16'h0);
        apb(1'b0, 2'd3, 16'h0, rdat, e, w);
        chk("midrst_result_err", e, 1'b1);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = 16'($urandom);
            b  = 16'($urandom);
            if ((op == 4'd8 || op == 4'd9) && $urandom_range(0, 3) == 0) b = 16'h0;
            if (op == 4'd5 && $urandom_range(0, 1) == 0) b = 16'($urandom_range(0, 255));
            run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, rw);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
